// File: rtl/axi_decerr_slave_pkg.sv
// Shared AXI response constants for the default/error responder.
// Only the DECERR code is consumed; the rest document the encoding.
package axi_decerr_slave_pkg;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExOkay = 2'b01;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

endpackage

// File: rtl/axi_decerr_rd.sv
// Read side of the DECERR responder: accepts one AR, returns len+1 DECERR beats.
// Valid/ready: a beat transfers on a cycle where both are high; r_* hold steady while r_valid_o waits.
module axi_decerr_rd
  import axi_decerr_slave_pkg::*;
#(
  parameter int unsigned         IdWidth   = 6,
  parameter int unsigned         DataWidth = 64,
  parameter logic [DataWidth-1:0] RdPattern = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [7:0]           ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic                 rdDone_o,
  output logic                 rdState_o
);

  typedef enum logic {R_IDLE, R_DATA} rdState_e;

  rdState_e           rdState, rdStateNext;
  logic [IdWidth-1:0] rdIdQ;
  logic [7:0]         lenQ;
  logic [7:0]         cntQ;
  logic               arHs;
  logic               rHs;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdState <= R_IDLE;
      rdIdQ   <= '0;
      lenQ    <= '0;
      cntQ    <= '0;
    end else begin
      rdState <= rdStateNext;
      if (arHs) begin
        rdIdQ <= ar_id_i;
        lenQ  <= ar_len_i;
        cntQ  <= '0;
      end else if (rHs && !r_last_o) begin
        // Final beat leaves cntQ at len, so len=255 never wraps the counter.
        cntQ <= cntQ + 8'd1;
      end
    end
  end

  always_comb begin
    rdStateNext = rdState;
    ar_ready_o  = 1'b0;
    r_valid_o   = 1'b0;
    if (!rst_i) begin
      unique case (rdState)
        R_IDLE: begin
          ar_ready_o = 1'b1;
          if (ar_valid_i) rdStateNext = R_DATA;
        end
        R_DATA: begin
          r_valid_o = 1'b1;
          if (r_ready_i && r_last_o) rdStateNext = R_IDLE;
        end
        default: rdStateNext = R_IDLE;
      endcase
    end
  end

  assign arHs      = ar_valid_i & ar_ready_o;
  assign rHs       = r_valid_o & r_ready_i;
  assign r_last_o  = (rdState == R_DATA) && (cntQ == lenQ);
  assign r_id_o    = rdIdQ;
  assign r_data_o  = RdPattern;
  assign r_resp_o  = RespDecErr;
  assign rdDone_o  = rHs & r_last_o;
  assign rdState_o = rdState;

endmodule

// File: rtl/axi_decerr_slave.sv
// Default AXI slave: completes every unmapped transaction with DECERR and counts them.
// Valid/ready: a transfer happens on a rising edge where both are high; valid never drops before that.
module axi_decerr_slave
  import axi_decerr_slave_pkg::*;
#(
  parameter int unsigned          IdWidth   = 6,
  parameter int unsigned          DataWidth = 64,
  parameter int unsigned          CntWidth  = 32,
  parameter logic [DataWidth-1:0] RdPattern = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [7:0]           ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic [CntWidth-1:0]  err_cnt_o
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wrState_e;

  wrState_e           wrState, wrStateNext;
  logic [IdWidth-1:0] wrIdQ;
  logic               awHs;
  logic               bHs;
  logic               rdDone;
  logic               rdState;
  logic [1:0]         errInc;
  logic [CntWidth:0]  errSum;
  logic [CntWidth-1:0] errCnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrState <= W_IDLE;
      wrIdQ   <= '0;
    end else begin
      wrState <= wrStateNext;
      if (awHs) wrIdQ <= aw_id_i;
    end
  end

  // W beats are only taken after AW, so early data stalls instead of being lost.
  always_comb begin
    wrStateNext = wrState;
    aw_ready_o  = 1'b0;
    w_ready_o   = 1'b0;
    b_valid_o   = 1'b0;
    if (!rst_i) begin
      unique case (wrState)
        W_IDLE: begin
          aw_ready_o = 1'b1;
          if (aw_valid_i) wrStateNext = W_DATA;
        end
        W_DATA: begin
          w_ready_o = 1'b1;
          if (w_valid_i && w_last_i) wrStateNext = W_RESP;
        end
        W_RESP: begin
          b_valid_o = 1'b1;
          if (b_ready_i) wrStateNext = W_IDLE;
        end
        default: wrStateNext = W_IDLE;
      endcase
    end
  end

  assign awHs     = aw_valid_i & aw_ready_o;
  assign bHs      = b_valid_o & b_ready_i;
  assign b_id_o   = wrIdQ;
  assign b_resp_o = RespDecErr;

  axi_decerr_rd #(
    .IdWidth  (IdWidth),
    .DataWidth(DataWidth),
    .RdPattern(RdPattern)
  ) i_rd (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ar_valid_i(ar_valid_i),
    .ar_ready_o(ar_ready_o),
    .ar_id_i   (ar_id_i),
    .ar_len_i  (ar_len_i),
    .r_valid_o (r_valid_o),
    .r_ready_i (r_ready_i),
    .r_id_o    (r_id_o),
    .r_data_o  (r_data_o),
    .r_resp_o  (r_resp_o),
    .r_last_o  (r_last_o),
    .rdDone_o  (rdDone),
    .rdState_o (rdState)
  );

  // One extra carry bit catches overflow of the +2 case as well as +1.
  assign errInc = {1'b0, bHs} + {1'b0, rdDone};
  assign errSum = {1'b0, errCnt} + {{(CntWidth - 1){1'b0}}, errInc};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      errCnt <= '0;
    end else if (errInc != 2'd0) begin
      errCnt <= errSum[CntWidth] ? {CntWidth{1'b1}} : errSum[CntWidth-1:0];
    end
  end

  assign err_cnt_o = errCnt;

endmodule
